ula_operand_stage: RTL and testbench
====================================

// Module: ula_operand_stage
// PURPOSE
//  Operand-fetch stage directly upstream of the ULA. Holds the 8x8 register file, selects
//  register or immediate for the second operand and presents SrcA/SrcB/ULAControl to the
//  ULA from a single pipeline register under a valid/ready handshake. A writeback port
//  updates the register file and forwards into both the read path and the held entry.
// PARAMETERS
//  DATA_W   8  operand/register width; must match the ULA data width
//  NREG     8  number of registers; register 0 reads as zero
//  CTRL_W   3  width of the ULA control field
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        upstream instruction fields are valid
//  in_ready     out  1        stage accepts an instruction this cycle
//  in_rs1       in   log2NREG source register A index
//  in_rs2       in   log2NREG source register B index
//  in_rd        in   log2NREG destination index, passed through
//  in_imm       in   DATA_W   immediate operand
//  in_use_imm   in   1        1: SrcB = in_imm; 0: SrcB = R[in_rs2]
//  in_ula_ctrl  in   CTRL_W   ULA operation, passed through
//  wb_en        in   1        writeback enable
//  wb_rd        in   log2NREG writeback register index
//  wb_data      in   DATA_W   writeback data
//  out_valid    out  1        SrcA/SrcB/ULAControl/out_rd hold a valid operation
//  out_ready    in   1        downstream consumes the held operation this cycle
//  SrcA         out  DATA_W   operand A to ULA
//  SrcB         out  DATA_W   operand B to ULA
//  ULAControl   out  CTRL_W   operation to ULA
//  out_rd       out  log2NREG destination index for the ULA result
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers R[*]=0; out_valid=0; SrcA=SrcB=0; ULAControl=0;
//   out_rd=0. Held entry discarded, even mid-stall. in_ready=1 on the first cycle after release.
//  Register file: write on clk edge when wb_en && wb_rd!=0. Writes to R0 are ignored.
//   Reads of R0 return 0.
//  Read path: combinational. If wb_en && wb_rd==rs && rs!=0, the read returns wb_data
//   (same-cycle bypass), else R[rs].
//  Handshake: in_ready = !out_valid || out_ready. Accept = in_valid && in_ready. Emit = out_valid && out_ready.
//  On Accept: next edge loads SrcA=read(rs1), SrcB = in_use_imm ? in_imm : read(rs2),
//   ULAControl, out_rd, stored rs1/rs2/use_imm. out_valid<=1. Latency 1 cycle.
//  On Emit without Accept: out_valid<=0. Outputs keep their last values.
//  Emit and Accept in the same cycle: new entry replaces old, out_valid stays 1 (full throughput).
//  Stall (out_valid && !out_ready): ULAControl/out_rd stable. If wb_en writes the held
//   entry's rs1 (!=0), SrcA<=wb_data. If it writes rs2 with use_imm=0, SrcB<=wb_data.
//   Otherwise SrcA/SrcB are stable.
//  rs1==rs2 with wb hit: both operands take wb_data.
//  in_valid=0: no state change except the register file and the stall forwarding.
//  Arithmetic: none. Widths are exact, no extension. The immediate is passed through unmodified.
// TESTING
//  1 Reset: rst_n=0 mid-stall with out_valid=1 -> out_valid=0, Src*=0 immediately (async),
//    all R read 0.
//  2 Basic: write R1=0x12, R2=0x34. Then issue rs1=1, rs2=2, ctrl=000, out_ready=1 ->
//    next cycle out_valid=1, SrcA=0x12, SrcB=0x34, ULAControl=000.
//  3 Bypass/R0: issue rs1=3 while wb_en, wb_rd=3, wb_data=0xA5 -> SrcA=0xA5.
//    Write R0=0xFF, then read R0 -> 0x00.
//  4 Immediate: rs2=2 (R2=0x34), use_imm=1, imm=0x07 -> SrcB=0x07.
//  5 Stall + forward: out_ready=0 with held rs2=4, use_imm=0. wb R4=0x5C -> SrcB becomes 0x5C
//    next cycle, in_ready=0, new in_valid is not accepted.
//  6 Throughput: in_valid=out_ready=1 for 8 back-to-back ops -> 8 emits in 8 consecutive
//    cycles, in order, no bubbles.

Source files
------------

// File: rtl/ula_operand_stage.sv
// Operand-fetch stage ahead of the ULA: register file with write bypass, immediate select
// and a single valid/ready output register that stays current with writebacks while stalled.
module ula_operand_stage #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int CTRL_W = 3,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_rs1,
    input  logic [IDX_W-1:0]  in_rs2,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [CTRL_W-1:0] in_ula_ctrl,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] SrcA,
    output logic [DATA_W-1:0] SrcB,
    output logic [CTRL_W-1:0] ULAControl,
    output logic [IDX_W-1:0]  out_rd
);

    logic [DATA_W-1:0] regs_q [NREG];

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] srca_q,    srca_d;
    logic [DATA_W-1:0] srcb_q,    srcb_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [IDX_W-1:0]  rd_q,      rd_d;
    logic [IDX_W-1:0]  rs1_q,     rs1_d;
    logic [IDX_W-1:0]  rs2_q,     rs2_d;
    logic              use_imm_q, use_imm_d;

    logic              wb_write;
    logic              accept;
    logic              stall;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign wb_write = wb_en && (wb_rd != '0);

    // Entry 0 has no write enable (wb_write excludes index 0), so it stays zero forever.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regfile
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[gi] <= '0;
            end else if (wb_write && (wb_rd == IDX_W'(gi))) begin
                regs_q[gi] <= wb_data;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_reg(input logic [IDX_W-1:0] rs);
        if (rs == '0) begin
            return '0;
        end else if (wb_write && (wb_rd == rs)) begin
            return wb_data;
        end else begin
            return regs_q[rs];
        end
    endfunction

    assign rd_a = read_reg(in_rs1);
    assign rd_b = read_reg(in_rs2);

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign stall    = valid_q && !out_ready;

    // A stall blocks accept, so the three branches below are mutually exclusive.
    always_comb begin
        valid_d   = valid_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        if (accept) begin
            valid_d   = 1'b1;
            srca_d    = rd_a;
            srcb_d    = in_use_imm ? in_imm : rd_b;
            ctrl_d    = in_ula_ctrl;
            rd_d      = in_rd;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            use_imm_d = in_use_imm;
        end else if (stall) begin
            if (wb_write && (wb_rd == rs1_q)) begin
                srca_d = wb_data;
            end
            if (wb_write && (wb_rd == rs2_q) && !use_imm_q) begin
                srcb_d = wb_data;
            end
        end else if (valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            srca_q    <= '0;
            srcb_q    <= '0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            srca_q    <= srca_d;
            srcb_q    <= srcb_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
        end
    end

    assign out_valid  = valid_q;
    assign SrcA       = srca_q;
    assign SrcB       = srcb_q;
    assign ULAControl = ctrl_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_ula_operand_stage.sv
// Bench for ula_operand_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the stage.
module tb_ula_operand_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_rs1, in_rs2, in_rd;
    logic [7:0] in_imm;
    logic       in_use_imm;
    logic [2:0] in_ula_ctrl;
    logic       wb_en;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] SrcA, SrcB;
    logic [2:0] ULAControl;
    logic [2:0] out_rd;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    ula_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_ula_ctrl(in_ula_ctrl),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ULAControl(ULAControl), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_r [8];
    logic       m_valid;
    logic [7:0] m_a, m_b;
    logic [2:0] m_ctrl, m_rd, m_rs1, m_rs2;
    logic       m_imm;
    logic       m_in_ready;
    assign m_in_ready = !m_valid || out_ready;

    function automatic logic [7:0] m_read(input logic [2:0] rs);
        if (rs == 3'd0) return 8'h00;
        if (wb_en && wb_rd == rs) return wb_data;
        return m_r[rs];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_r[i] <= 8'h00;
            m_valid <= 1'b0; m_a <= 8'h00; m_b <= 8'h00;
            m_ctrl <= 3'd0; m_rd <= 3'd0; m_rs1 <= 3'd0; m_rs2 <= 3'd0; m_imm <= 1'b0;
        end else begin
            if (wb_en && wb_rd != 3'd0) m_r[wb_rd] <= wb_data;
            if (in_valid && m_in_ready) begin
                m_valid <= 1'b1;
                m_a     <= m_read(in_rs1);
                m_b     <= in_use_imm ? in_imm : m_read(in_rs2);
                m_ctrl  <= in_ula_ctrl;
                m_rd    <= in_rd;
                m_rs1   <= in_rs1;
                m_rs2   <= in_rs2;
                m_imm   <= in_use_imm;
            end else if (m_valid && !out_ready) begin
                if (wb_en && wb_rd != 3'd0 && wb_rd == m_rs1) m_a <= wb_data;
                if (wb_en && wb_rd != 3'd0 && wb_rd == m_rs2 && !m_imm) m_b <= wb_data;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && check_en) begin
            chk("cmp out_valid",  int'(out_valid),  int'(m_valid));
            chk("cmp in_ready",   int'(in_ready),   int'(m_in_ready));
            chk("cmp SrcA",       int'(SrcA),       int'(m_a));
            chk("cmp SrcB",       int'(SrcB),       int'(m_b));
            chk("cmp ULAControl", int'(ULAControl), int'(m_ctrl));
            chk("cmp out_rd",     int'(out_rd),     int'(m_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0;
        in_use_imm = 0; in_ula_ctrl = 0; wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
    endtask

    task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2, input logic imm_sel,
                         input logic [7:0] imm, input logic [2:0] ctrl, input logic [2:0] rd);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_use_imm = imm_sel;
        in_imm = imm; in_ula_ctrl = ctrl; in_rd = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12 rst_n = 1'b1;
        check_en = 1'b1;
        chk("post-reset in_ready", int'(in_ready), 1);
        chk("post-reset out_valid", int'(out_valid), 0);

        // Basic: R1=0x12, R2=0x34, then add R1,R2
        wb_en = 1; wb_rd = 1; wb_data = 8'h12; tick();
        wb_rd = 2; wb_data = 8'h34; tick();
        wb_en = 0; out_ready = 1;
        issue(3'd1, 3'd2, 1'b0, 8'h00, 3'd0, 3'd1); tick();
        in_valid = 0;
        chk("basic out_valid", int'(out_valid), 1);
        chk("basic SrcA", int'(SrcA), 8'h12);
        chk("basic SrcB", int'(SrcB), 8'h34);
        chk("basic ULAControl", int'(ULAControl), 0);

        // Same-cycle bypass and R0
        issue(3'd3, 3'd1, 1'b0, 8'h00, 3'd2, 3'd3);
        wb_en = 1; wb_rd = 3; wb_data = 8'hA5; tick();
        chk("bypass SrcA", int'(SrcA), 8'hA5);
        chk("bypass SrcB", int'(SrcB), 8'h12);
        in_valid = 0; wb_rd = 0; wb_data = 8'hFF; tick();
        wb_en = 0;
        issue(3'd0, 3'd0, 1'b0, 8'h00, 3'd1, 3'd0); tick();
        chk("R0 SrcA", int'(SrcA), 0);
        chk("R0 SrcB", int'(SrcB), 0);

        // Immediate select
        issue(3'd1, 3'd2, 1'b1, 8'h07, 3'd5, 3'd6); tick();
        chk("imm SrcB", int'(SrcB), 8'h07);
        chk("imm ULAControl", int'(ULAControl), 5);
        chk("imm out_rd", int'(out_rd), 6);

        // Stall with forwarding into the held entry
        issue(3'd1, 3'd4, 1'b0, 8'h00, 3'd3, 3'd2); tick();
        in_valid = 0; out_ready = 0;
        wb_en = 1; wb_rd = 4; wb_data = 8'h5C; tick();
        wb_en = 0;
        chk("stall fwd SrcB", int'(SrcB), 8'h5C);
        chk("stall SrcA", int'(SrcA), 8'h12);
        issue(3'd2, 3'd2, 1'b0, 8'h00, 3'd7, 3'd7); #1;
        chk("stall in_ready", int'(in_ready), 0);
        tick();
        chk("stall held ctrl", int'(ULAControl), 3);
        chk("stall held rd", int'(out_rd), 2);
        chk("stall out_valid", int'(out_valid), 1);

        // Asynchronous reset in the middle of the stall
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", int'(out_valid), 0);
        chk("async rst SrcA", int'(SrcA), 0);
        chk("async rst SrcB", int'(SrcB), 0);
        chk("async rst ULAControl", int'(ULAControl), 0);
        idle_inputs();
        #3 rst_n = 1'b1;
        chk("async rst in_ready", int'(in_ready), 1);
        out_ready = 1;
        for (int i = 1; i < 8; i++) begin
            issue(3'(i), 3'(i), 1'b0, 8'h00, 3'd0, 3'd0); tick();
            chk("post-rst R read A", int'(SrcA), 0);
            chk("post-rst R read B", int'(SrcB), 0);
        end
        in_valid = 0; tick();

        // Throughput: 8 back-to-back ops, one emit per cycle in order
        for (int i = 0; i < 8; i++) begin
            wb_en = 1; wb_rd = 3'(i); wb_data = 8'(8'h40 + i); tick();
        end
        wb_en = 0;
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 3'd0, 1'b1, 8'(i * 3), 3'(i), 3'(7 - i)); tick();
            chk("thru out_valid", int'(out_valid), 1);
            chk("thru ULAControl", int'(ULAControl), i);
            chk("thru SrcA", int'(SrcA), (i == 0) ? 0 : 8'h40 + i);
            chk("thru SrcB", int'(SrcB), i * 3);
        end
        in_valid = 0; tick();
        chk("drain out_valid", int'(out_valid), 0);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_rs1      = 3'($urandom_range(0, 7));
            in_rs2      = 3'($urandom_range(0, 7));
            in_rd       = 3'($urandom_range(0, 7));
            in_imm      = 8'($urandom_range(0, 255));
            in_use_imm  = 1'($urandom_range(0, 1));
            in_ula_ctrl = 3'($urandom_range(0, 7));
            wb_en       = 1'($urandom_range(0, 1));
            wb_rd       = 3'($urandom_range(0, 7));
            wb_data     = 8'($urandom_range(0, 255));
            out_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
